// File: rtl/sseg_capture.sv
// Seven-segment display readback: recovers the four scanned hex digits,
// decimal points and blank/invalid flags from the active-low an/sseg lines.
module sseg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [15:0] hex_out,
    output logic [3:0]  dp_out,
    output logic [3:0]  blank,
    output logic [3:0]  invalid,
    output logic        frame_valid,
    output logic        stale
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [8:0] STB     = 9'(STABLE_CYCLES);
    localparam logic [8:0] RUN_MAX = 9'(STABLE_CYCLES + 1);

    logic [3:0]    r_an;
    logic [7:0]    r_sseg;
    logic [8:0]    r_run;
    logic [15:0]   r_s_hex;
    logic [3:0]    r_s_dp;
    logic [3:0]    r_s_blk;
    logic [3:0]    r_s_inv;
    logic [3:0]    r_seen;
    logic [15:0]   r_hex;
    logic [3:0]    r_dp;
    logic [3:0]    r_blk;
    logic [3:0]    r_inv;
    logic          r_fv;
    logic          r_stale;
    logic [TW-1:0] r_timer;

    logic       w_qual;
    logic       w_acc;
    logic       w_full;
    logic [1:0] w_idx;
    logic [3:0] w_sel;
    logic [3:0] w_dig;
    logic       w_blk;
    logic       w_inv;
    logic       w_dp;

    always_comb begin
        w_qual = 1'b0;
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_qual = 1'b1;
            default: w_qual = 1'b0;
        endcase
    end

    always_comb begin
        w_idx = 2'd0;
        case (r_an)
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // A run of exactly STABLE_CYCLES accepts the value held in r_an/r_sseg
    assign w_acc  = (r_run == STB);
    assign w_full = (r_seen == 4'hF);
    assign w_sel  = 4'(1) << w_idx;
    assign w_dp   = ~r_sseg[7];

    always_comb begin
        w_dig = 4'h0;
        w_blk = 1'b0;
        w_inv = 1'b0;
        case (r_sseg[6:0])
            7'b1000000: w_dig = 4'h0;
            7'b1111001: w_dig = 4'h1;
            7'b0100100: w_dig = 4'h2;
            7'b0110000: w_dig = 4'h3;
            7'b0011001: w_dig = 4'h4;
            7'b0010010: w_dig = 4'h5;
            7'b0000010: w_dig = 4'h6;
            7'b1111000: w_dig = 4'h7;
            7'b0000000: w_dig = 4'h8;
            7'b0010000: w_dig = 4'h9;
            7'b0001000: w_dig = 4'hA;
            7'b0000011: w_dig = 4'hB;
            7'b1000110: w_dig = 4'hC;
            7'b0100001: w_dig = 4'hD;
            7'b0000110: w_dig = 4'hE;
            7'b0001110: w_dig = 4'hF;
            7'b1111111: w_blk = 1'b1;
            default:    w_inv = 1'b1;
        endcase
    end

    // Stability run; saturating one past the threshold gives a single accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an   <= 4'hF;
            r_sseg <= 8'hFF;
            r_run  <= '0;
        end else begin
            r_an   <= an;
            r_sseg <= sseg;
            if (!w_qual) begin
                r_run <= '0;
            end else if (an == r_an && sseg == r_sseg) begin
                if (r_run != RUN_MAX) begin
                    r_run <= r_run + 9'd1;
                end
            end else begin
                r_run <= 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_hex <= '0;
            r_s_dp  <= '0;
            r_s_blk <= '0;
            r_s_inv <= '0;
            r_seen  <= '0;
            r_hex   <= '0;
            r_dp    <= '0;
            r_blk   <= 4'hF;
            r_inv   <= '0;
            r_fv    <= 1'b0;
            r_stale <= 1'b0;
            r_timer <= '0;
        end else begin
            r_fv <= w_full;
            if (w_acc) begin
                r_s_hex[{w_idx, 2'b00} +: 4] <= w_dig;
                r_s_dp[w_idx]  <= w_dp;
                r_s_blk[w_idx] <= w_blk;
                r_s_inv[w_idx] <= w_inv;
            end
            // Frame copy reads the old slots; a same-edge accept seeds the next frame
            if (w_full) begin
                r_hex   <= r_s_hex;
                r_dp    <= r_s_dp;
                r_blk   <= r_s_blk;
                r_inv   <= r_s_inv;
                r_seen  <= w_acc ? w_sel : 4'h0;
                r_timer <= '0;
                r_stale <= 1'b0;
            end else begin
                if (w_acc) begin
                    r_seen <= r_seen | w_sel;
                end
                if (r_timer != TMAX) begin
                    r_timer <= r_timer + TW'(1);
                    if (r_timer == TMAX - TW'(1)) begin
                        r_stale <= 1'b1;
                    end
                end
            end
        end
    end

    assign hex_out     = r_hex;
    assign dp_out      = r_dp;
    assign blank       = r_blk;
    assign invalid     = r_inv;
    assign frame_valid = r_fv;
    assign stale       = r_stale;

endmodule

// File: tb/tb_sseg_capture.sv
// Scoreboard bench for sseg_capture: expected frames are queued as scans
// are driven and checked whenever frame_valid pulses.
module tb_sseg_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  an = 4'hF;
    logic [7:0]  sseg = 8'hFF;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  blank;
    logic [3:0]  invalid;
    logic        frame_valid;
    logic        stale;

    always #5 clk = ~clk;

    sseg_capture #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(100)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .sseg       (sseg),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .blank      (blank),
        .invalid    (invalid),
        .frame_valid(frame_valid),
        .stale      (stale)
    );

    typedef struct packed {
        logic [15:0] h;
        logic [3:0]  d;
        logic [3:0]  b;
        logic [3:0]  v;
    } frm_t;

    frm_t       q[$];
    int         total = 0;
    int         bad = 0;
    logic [6:0] seg_tab[16];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [3:0] a, input logic [7:0] s, input int n);
        an   = a;
        sseg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dig_raw(input int i, input logic [7:0] s, input int n);
        logic [3:0] m;
        m = 4'b0001 << i;
        put(~m, s, n);
        put(4'hF, 8'hFF, 2);
    endtask

    task automatic dig(input int i, input logic [3:0] v, input logic dp,
                       input int n);
        dig_raw(i, {~dp, seg_tab[v]}, n);
    endtask

    task automatic scan(input logic [15:0] h, input logic [3:0] d);
        q.push_back('{h: h, d: d, b: 4'h0, v: 4'h0});
        for (int i = 3; i >= 0; i--) begin
            dig(i, h[4*i +: 4], d[i], 16);
        end
    endtask

    always @(negedge clk) begin : mon
        frm_t e;
        if (!reset && frame_valid) begin
            if (q.size() == 0) begin
                check("spurious_frame", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("hex_out", 32'(hex_out), 32'(e.h));
                check("dp_out", 32'(dp_out), 32'(e.d));
                check("blank", 32'(blank), 32'(e.b));
                check("invalid", 32'(invalid), 32'(e.v));
                check("stale_at_frame", 32'(stale), 32'd0);
            end
        end
    end

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hex", 32'(hex_out), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h0);
        check("rst_blank", 32'(blank), 32'hF);
        check("rst_invalid", 32'(invalid), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: stale rises on the 100th edge
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("stale_99", 32'(stale), 32'd0);
        @(negedge clk);
        check("stale_100", 32'(stale), 32'd1);
        @(posedge clk);
        #1;

        scan(16'h1234, 4'b0000);

        // 3-cycle hold is too short; the 4-cycle hold is accepted
        dig(3, 4'hA, 1'b0, 16);
        dig(2, 4'hB, 1'b0, 16);
        dig(1, 4'hC, 1'b0, 16);
        dig(0, 4'h7, 1'b0, 3);
        repeat (8) @(posedge clk);
        #1;
        q.push_back('{h: 16'hABC7, d: 4'h0, b: 4'h0, v: 4'h0});
        put(4'b1110, {1'b1, seg_tab[7]}, 4);
        an   = 4'hF;
        sseg = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        check("fv_edge5", 32'(frame_valid), 32'd0);
        @(negedge clk);
        check("fv_edge6", 32'(frame_valid), 32'd1);
        @(negedge clk);
        check("fv_edge7", 32'(frame_valid), 32'd0);
        @(posedge clk);
        #1;

        // Illegal and blank patterns
        q.push_back('{h: 16'h0000, d: 4'b0100, b: 4'b0100, v: 4'b0010});
        dig(3, 4'h0, 1'b0, 16);
        dig_raw(2, 8'b0111_1111, 16);
        dig_raw(1, 8'b1010_1010, 16);
        dig(0, 4'h0, 1'b0, 16);

        // Ghosting between valid digits is ignored
        q.push_back('{h: 16'h5621, d: 4'h0, b: 4'h0, v: 4'h0});
        dig(0, 4'h1, 1'b0, 16);
        dig(1, 4'h2, 1'b0, 16);
        put(4'b0011, {1'b1, seg_tab[8]}, 20);
        put(4'hF, 8'hFF, 2);
        dig(2, 4'h6, 1'b0, 16);
        dig(3, 4'h5, 1'b0, 16);

        // Re-accepted digit overwrites its slot
        q.push_back('{h: 16'h3459, d: 4'h0, b: 4'h0, v: 4'h0});
        dig(0, 4'h1, 1'b0, 16);
        dig(0, 4'h9, 1'b0, 16);
        dig(1, 4'h5, 1'b0, 16);
        dig(2, 4'h4, 1'b0, 16);
        dig(3, 4'h3, 1'b0, 16);

        scan(16'h5678, 4'b0001);
        scan(16'h9ABC, 4'b1010);
        scan(16'hDEF0, 4'b0101);

        // Reset mid-frame discards partial progress
        dig(0, 4'h1, 1'b0, 16);
        dig(1, 4'h2, 1'b0, 16);
        dig(2, 4'h4, 1'b0, 16);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        dig(3, 4'h8, 1'b0, 16);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_rst_hex", 32'(hex_out), 32'h0);
        check("mid_rst_blank", 32'(blank), 32'hF);
        check("mid_rst_dp", 32'(dp_out), 32'h0);
        check("mid_rst_inv", 32'(invalid), 32'h0);
        @(posedge clk);
        #1;
        scan(16'h8421, 4'b0000);

        for (int k = 0; k < 100 && q.size() != 0; k++) begin
            @(posedge clk);
        end
        #1;
        check("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
